// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types for the table-driven I2C register sequencer.
//   - opcode constants for the 26-bit table entry
//   - packed entry layout (op, rsv, dev, sub-address, data)
//   - sequencer state enum
package i2c_seq_pkg;

    localparam int ENTRY_W = 26;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;   // reserved opcode, executed as a no-op
    localparam logic [1:0] OP_END   = 2'b11;

    // 'sub' is the register sub-address byte; 'reg' is a keyword.
    typedef struct packed {
        logic [1:0] op;
        logic       rsv;
        logic [6:0] dev;
        logic [7:0] sub;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_WAIT_ACC,
        S_WAIT_END,
        S_DELAY,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/i2c_seq_tick.sv
// i2c_seq_tick: TICK_CYC-cycle prescaler driving a 16-bit tick down-counter.
// Shared by the power-up wait and by DELAY entries.
//   iCLK, iRST_N : clock, async active-low reset (counter resets to RST_TICKS)
//   load         : load 'ticks' and restart the prescaler
//   ticks        : tick count to wait
//   expired      : high when the count is already zero, or reaches zero on
//                  the coming edge, so a waiting FSM spends exactly
//                  ticks*TICK_CYC cycles in its wait state
module i2c_seq_tick #(
    parameter int TICK_CYC  = 50_000,
    parameter int RST_TICKS = 0
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        load,
    input  logic [15:0] ticks,
    output logic        expired
);

    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [PW-1:0] pre;
    logic [15:0]   cnt;
    logic          pre_last;

    assign pre_last = (pre == PW'(TICK_CYC - 1));
    assign expired  = (cnt == 16'd0) || ((cnt == 16'd1) && pre_last);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pre <= '0;
            cnt <= 16'(RST_TICKS);
        end else if (load) begin
            pre <= '0;
            cnt <= ticks;
        end else if (cnt != 16'd0) begin
            if (pre_last) begin
                pre <= '0;
                cnt <= cnt - 16'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: walks a ROM of opcode entries and drives the shared
// I2C master through its start/end handshake.
//   iCLK, iRST_N          : clock, async active-low reset
//   restart               : pulse; re-run the table from entry 0
//   tbl_idx / tbl_data    : ROM address out, entry back one cycle later
//   i2c_start/dev/reg/data: transfer request and payload to the master
//   i2c_end, i2c_nack     : master idle flag, NACK status valid as end rises
//   busy, done            : sequence running / finished
//   error, err_idx        : sticky failure flag and first failing index
//   nack_cnt              : NACKs seen this run, saturating
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int MAX_RETRY  = 3,
    parameter int TICK_CYC   = 50_000,
    parameter int BOOT_TICKS = 0,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               restart,
    output logic [IDX_W-1:0]   tbl_idx,
    input  logic [ENTRY_W-1:0] tbl_data,
    output logic               i2c_start,
    output logic [6:0]         i2c_dev,
    output logic [7:0]         i2c_reg,
    output logic [7:0]         i2c_data,
    input  logic               i2c_end,
    input  logic               i2c_nack,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   err_idx,
    output logic [7:0]         nack_cnt
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t        state, state_nxt;
    entry_t        ent;
    logic [RW-1:0] retry_cnt;
    logic          restart_pend, pend;
    logic          tick_ld, tick_exp;
    logic          issue, accepted, complete, finish;
    logic          retry, fail, nack_evt, inc_idx, do_restart, boot_exit;
    logic          unused_rsv;

    assign ent        = entry_t'(tbl_data);
    assign unused_rsv = ent.rsv;
    assign pend       = restart_pend | restart;
    assign boot_exit  = (state == S_BOOT) && tick_exp;
    assign busy       = (state != S_DONE);
    assign done       = (state == S_DONE);

    i2c_seq_tick #(
        .TICK_CYC  (TICK_CYC),
        .RST_TICKS (BOOT_TICKS)
    ) u_tick (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .load    (tick_ld),
        .ticks   ({ent.sub, ent.data}),
        .expired (tick_exp)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= S_BOOT;
        else         state <= state_nxt;
    end

    // 'complete' marks the end of an entry (would enter NEXT), 'finish' the
    // end of the table (would enter DONE). A pending restart takes over at
    // either point, so a run in progress never reports done.
    always_comb begin
        state_nxt  = state;
        tick_ld    = 1'b0;
        issue      = 1'b0;
        accepted   = 1'b0;
        complete   = 1'b0;
        finish     = 1'b0;
        retry      = 1'b0;
        fail       = 1'b0;
        nack_evt   = 1'b0;
        inc_idx    = 1'b0;
        do_restart = 1'b0;
        case (state)
            S_BOOT:  if (tick_exp) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (ent.op)
                    OP_WRITE: begin
                        issue     = 1'b1;
                        state_nxt = S_WAIT_ACC;
                    end
                    OP_DELAY: begin
                        tick_ld   = 1'b1;
                        state_nxt = S_DELAY;
                    end
                    OP_END:  finish   = 1'b1;
                    default: complete = 1'b1;
                endcase
            end
            S_WAIT_ACC: begin
                if (!i2c_end) begin
                    accepted  = 1'b1;
                    state_nxt = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (i2c_end) begin
                    if (!i2c_nack) begin
                        complete = 1'b1;
                    end else begin
                        nack_evt = 1'b1;
                        if (retry_cnt == RW'(MAX_RETRY)) begin
                            fail     = 1'b1;
                            complete = 1'b1;
                        end else begin
                            retry     = 1'b1;
                            state_nxt = S_DECODE;
                        end
                    end
                end
            end
            S_DELAY: if (tick_exp) complete = 1'b1;
            S_NEXT: begin
                if (tbl_idx == IDX_W'(DEPTH - 1)) begin
                    finish = 1'b1;
                end else begin
                    inc_idx   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE:  if (restart) do_restart = 1'b1;
            default: state_nxt = S_BOOT;
        endcase
        if (complete) state_nxt = S_NEXT;
        if (finish)   state_nxt = S_DONE;
        if ((complete || finish) && pend) do_restart = 1'b1;
        if (do_restart) begin
            state_nxt = S_FETCH;
            inc_idx   = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tbl_idx      <= '0;
            i2c_start    <= 1'b0;
            i2c_dev      <= '0;
            i2c_reg      <= '0;
            i2c_data     <= '0;
            retry_cnt    <= '0;
            restart_pend <= 1'b0;
            error        <= 1'b0;
            err_idx      <= '0;
            nack_cnt     <= '0;
        end else begin
            if (do_restart)   tbl_idx <= '0;
            else if (inc_idx) tbl_idx <= tbl_idx + IDX_W'(1);

            // payload only changes on issue, so it stays put through retries
            if (issue) begin
                i2c_start <= 1'b1;
                i2c_dev   <= ent.dev;
                i2c_reg   <= ent.sub;
                i2c_data  <= ent.data;
            end else if (accepted) begin
                i2c_start <= 1'b0;
            end

            if (retry)         retry_cnt <= retry_cnt + RW'(1);
            else if (complete) retry_cnt <= '0;

            // a restart before the first entry starts is already satisfied
            if (do_restart || boot_exit) restart_pend <= 1'b0;
            else if (restart)            restart_pend <= 1'b1;

            if (do_restart) begin
                error    <= 1'b0;
                err_idx  <= '0;
                nack_cnt <= '0;
            end else begin
                if (nack_evt && (nack_cnt != 8'hFF)) nack_cnt <= nack_cnt + 8'd1;
                if (fail) begin
                    error <= 1'b1;
                    if (!error) err_idx <= tbl_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench: stimulus pushes expected {dev,reg,data} per transfer and
// the NACK plan for the master model; a monitor pops on every i2c_start rise.
module tb_i2c_reg_sequencer;

    localparam logic [25:0] ENDE = {2'b11, 24'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, rst2_n, restart;
    int          n_cmp = 0, n_bad = 0, n_starts = 0, n_starts2 = 0;
    logic [22:0] exp_q[$], exp2_q[$];
    logic        nack_q[$];
    int          start_cyc_q[$];

    // main DUT: DEPTH 16, MAX_RETRY 3, TICK_CYC 10, BOOT_TICKS 2
    logic [3:0]  tbl_idx, err_idx;
    logic [25:0] tbl_data;
    logic [25:0] rom [16];
    logic        i2c_start, i2c_end, i2c_nack, busy, done, error;
    logic [6:0]  i2c_dev;
    logic [7:0]  i2c_reg, i2c_data, nack_cnt;
    always @(posedge clk) tbl_data <= rom[tbl_idx];

    i2c_reg_sequencer #(.DEPTH(16), .MAX_RETRY(3), .TICK_CYC(10), .BOOT_TICKS(2)) dut (
        .iCLK(clk), .iRST_N(rst_n), .restart(restart), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .i2c_start(i2c_start), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
        .i2c_end(i2c_end), .i2c_nack(i2c_nack), .busy(busy), .done(done), .error(error),
        .err_idx(err_idx), .nack_cnt(nack_cnt));

    // small DUT: DEPTH 4 table with no END entry, MAX_RETRY 0
    logic [1:0]  tbl_idx2, err_idx2;
    logic [25:0] tbl_data2;
    logic [25:0] rom2 [4];
    logic        i2c_start2, i2c_end2, busy2, done2, error2;
    logic        nack2 = 1'b0;
    logic        restart2 = 1'b0;
    logic [6:0]  i2c_dev2;
    logic [7:0]  i2c_reg2, i2c_data2, nack_cnt2;
    always @(posedge clk) tbl_data2 <= rom2[tbl_idx2];

    i2c_reg_sequencer #(.DEPTH(4), .MAX_RETRY(0), .TICK_CYC(10), .BOOT_TICKS(0)) dut2 (
        .iCLK(clk), .iRST_N(rst2_n), .restart(restart2), .tbl_idx(tbl_idx2), .tbl_data(tbl_data2),
        .i2c_start(i2c_start2), .i2c_dev(i2c_dev2), .i2c_reg(i2c_reg2), .i2c_data(i2c_data2),
        .i2c_end(i2c_end2), .i2c_nack(nack2), .busy(busy2), .done(done2), .error(error2),
        .err_idx(err_idx2), .nack_cnt(nack_cnt2));

    function automatic logic [25:0] wr(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        return {2'b00, 1'b0, d, r, v};
    endfunction

    function automatic logic [25:0] dly(input logic [15:0] t);
        return {2'b01, 1'b0, 7'd0, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic ex(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        exp_q.push_back({d, r, v});
    endtask

    task automatic push_nacks(input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) nack_q.push_back(pat[i]);
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, done, 1);
    endtask

    task automatic wait_starts(input string nm, input int target);
        int t = 0;
        while (n_starts < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, n_starts >= target, 1);
    endtask

    // master models: accept a request by dropping end, finish 3 cycles later
    initial begin
        i2c_end = 1'b1;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start && i2c_end) begin
                i2c_end = 1'b0;
                repeat (3) @(negedge clk);
                i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                i2c_end = 1'b1;
            end
        end
    end

    initial begin
        i2c_end2 = 1'b1;
        forever begin
            @(negedge clk);
            if (i2c_start2 && i2c_end2) begin
                i2c_end2 = 1'b0;
                repeat (3) @(negedge clk);
                i2c_end2 = 1'b1;
            end
        end
    end

    // monitors
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start && !prev) begin
                n_starts++;
                start_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL xfer: unexpected start %h/%h/%h", i2c_dev, i2c_reg, i2c_data);
                end else begin
                    chk("xfer", {i2c_dev, i2c_reg, i2c_data}, exp_q.pop_front());
                end
            end
            prev = i2c_start;
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start2 && !prev) begin
                n_starts2++;
                if (exp2_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL xfer2: unexpected start %h/%h/%h", i2c_dev2, i2c_reg2, i2c_data2);
                end else begin
                    chk("xfer2", {i2c_dev2, i2c_reg2, i2c_data2}, exp2_q.pop_front());
                end
            end
            prev = i2c_start2;
        end
    end

    initial begin
        int base, rel;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        restart = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = ENDE;
        for (int i = 0; i < 4; i++) begin
            rom2[i] = wr(7'h2A, 8'(i), 8'(8'h80 + i));
            exp2_q.push_back({7'h2A, 8'(i), 8'(8'h80 + i)});
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_nack", nack_cnt, 0);
        chk("rst_idx", tbl_idx, 0);
        chk("rst_start", i2c_start, 0);
        chk("rst_dev", {i2c_dev, i2c_reg, i2c_data}, 0);
        chk("rst_erridx", err_idx, 0);

        // T1: three ACKed writes, then END
        rom[0] = wr(7'h39, 8'h98, 8'h03);
        rom[1] = wr(7'h39, 8'h41, 8'h10);
        rom[2] = wr(7'h39, 8'hD6, 8'hC0);
        ex(7'h39, 8'h98, 8'h03); ex(7'h39, 8'h41, 8'h10); ex(7'h39, 8'hD6, 8'hC0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        wait_done("t1_done");
        chk("t1_error", error, 0);
        chk("t1_nack", nack_cnt, 0);
        chk("t1_busy", busy, 0);
        chk("t1_drain", exp_q.size(), 0);

        // T2: entry 1 NACKs twice then ACKs
        push_nacks(5, 16'b00110);
        ex(7'h39, 8'h98, 8'h03);
        repeat (3) ex(7'h39, 8'h41, 8'h10);
        ex(7'h39, 8'hD6, 8'hC0);
        pulse_restart();
        wait_done("t2_done");
        chk("t2_nack", nack_cnt, 2);
        chk("t2_error", error, 0);
        chk("t2_drain", exp_q.size(), 0);

        // T3: entry 2 always NACKs -> 4 attempts, skipped, entry 3 still runs
        for (int i = 0; i < 4; i++) rom[i] = wr(7'h50, 8'(i), 8'(i + 1));
        rom[4] = ENDE;
        push_nacks(7, 16'b0111100);
        ex(7'h50, 8'h00, 8'h01); ex(7'h50, 8'h01, 8'h02);
        repeat (4) ex(7'h50, 8'h02, 8'h03);
        ex(7'h50, 8'h03, 8'h04);
        pulse_restart();
        wait_done("t3_done");
        chk("t3_error", error, 1);
        chk("t3_erridx", err_idx, 2);
        chk("t3_nack", nack_cnt, 4);
        chk("t3_drain", exp_q.size(), 0);

        // T4: DELAY of 5 ticks x 10 cycles between entries 2 and 4.
        // Extra start-to-start spacing vs a plain gap: DECODE(delay) + 50 + NEXT + FETCH = 53.
        rom[0] = wr(7'h20, 8'h00, 8'hAA);
        rom[1] = wr(7'h20, 8'h01, 8'hBB);
        rom[2] = wr(7'h20, 8'h02, 8'hCC);
        rom[3] = dly(16'd5);
        rom[4] = wr(7'h20, 8'h03, 8'hDD);
        rom[5] = ENDE;
        ex(7'h20, 8'h00, 8'hAA); ex(7'h20, 8'h01, 8'hBB); ex(7'h20, 8'h02, 8'hCC); ex(7'h20, 8'h03, 8'hDD);
        base = start_cyc_q.size();
        pulse_restart();
        wait_done("t4_done");
        chk("t4_error_clr", error, 0);
        chk("t4_erridx_clr", err_idx, 0);
        chk("t4_delay", (start_cyc_q[base+3] - start_cyc_q[base+2]) - (start_cyc_q[base+2] - start_cyc_q[base+1]), 53);

        // T5: restart pulsed during entry 4 -> entry 4 completes, rerun from 0
        for (int i = 0; i < 6; i++) rom[i] = wr(7'h11, 8'(i), 8'(i));
        rom[6] = ENDE;
        push_nacks(6, 16'b000100);
        for (int i = 0; i < 5; i++) begin
            ex(7'h11, 8'(i), 8'(i));
            if (i == 2) ex(7'h11, 8'(i), 8'(i));
        end
        for (int i = 0; i < 6; i++) ex(7'h11, 8'(i), 8'(i));
        base = n_starts;
        pulse_restart();
        wait_starts("t5_reach_e4", base + 6);
        pulse_restart();
        wait_starts("t5_rerun", base + 7);
        chk("t5_nack_clr", nack_cnt, 0);
        chk("t5_no_done", done, 0);
        chk("t5_idx0", tbl_idx, 0);
        wait_done("t5_done");
        chk("t5_nack", nack_cnt, 0);
        chk("t5_drain", exp_q.size(), 0);

        // T6: async reset while entry 1 waits for the master to finish
        rom[0] = wr(7'h33, 8'h01, 8'h02);
        rom[1] = wr(7'h33, 8'h03, 8'h04);
        rom[2] = ENDE;
        ex(7'h33, 8'h01, 8'h02); ex(7'h33, 8'h03, 8'h04);
        base = n_starts;
        pulse_restart();
        wait_starts("t6_reach_e1", base + 2);
        for (int t = 0; t < 20 && i2c_start; t++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_start", i2c_start, 0);
        chk("t6_busy", busy, 1);
        chk("t6_done", done, 0);
        chk("t6_idx", tbl_idx, 0);
        ex(7'h33, 8'h01, 8'h02); ex(7'h33, 8'h03, 8'h04);
        base = start_cyc_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_done("t6_redone");
        // BOOT 2 ticks x 10 = 20 cycles, then FETCH and DECODE
        chk("t6_boot", start_cyc_q[base] - rel, 22);
        chk("t6_drain", exp_q.size(), 0);

        // small DUT: no END entry, stops after index 3
        chk("s_done", done2, 1);
        chk("s_idx", tbl_idx2, 3);
        chk("s_starts", n_starts2, 4);
        chk("s_drain", exp2_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
